// File: rtl/mem_responder.sv
// mem_responder: fixed-latency memory-side responder for the mp2 CPU memory port.
// Define MEM_RESP_PROTOCOL_CHECK_EN to compile in the sticky proto_err checker.
module mem_responder #(
   parameter int ADDR_BITS = 8,
   parameter int LATENCY   = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [3:0]  mem_byte_enable,
   input  logic [31:0] mem_address,
   input  logic [31:0] mem_wdata,
   output logic        mem_resp,
   output logic [31:0] mem_rdata,
   output logic        proto_err
);

   localparam int DEPTH = 1 << ADDR_BITS;
   // Count loaded on acceptance so that RESP lands exactly LATENCY cycles later.
   localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [3:0]           cnt_q, cnt_d;
   logic [ADDR_BITS-1:0] idx_q, idx_d;
   logic [31:0]          wdata_q, wdata_d;
   logic [3:0]           be_q, be_d;
   logic                 is_write_q, is_write_d;
   logic                 resp_q;
   logic [31:0]          rdata_q;

   logic [31:0]          mem_array [DEPTH];

   logic                 req;
   logic [ADDR_BITS-1:0] req_idx;
   logic [ADDR_BITS-1:0] rd_idx;
   logic                 load_rdata;
   logic                 commit;

   assign req     = mem_read | mem_write;
   assign req_idx = mem_address[ADDR_BITS+1:2];

   generate
      if (ADDR_BITS < 30) begin : g_alias
         logic unused_addr_bits;
         assign unused_addr_bits = ^{mem_address[31:ADDR_BITS+2], mem_address[1:0]};
      end else begin : g_noalias
         logic unused_addr_bits;
         assign unused_addr_bits = ^mem_address[1:0];
      end
   endgenerate

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      wdata_d    = wdata_q;
      be_d       = be_q;
      is_write_d = is_write_q;
      case (state_q)
         IDLE: begin
            if (req) begin
               idx_d      = req_idx;
               wdata_d    = mem_wdata;
               be_d       = mem_byte_enable;
               is_write_d = mem_write;
               if (LATENCY == 1) begin
                  state_d = RESP;
               end else begin
                  state_d = BUSY;
                  cnt_d   = CNT_INIT;
               end
            end
         end
         BUSY: begin
            if (cnt_q == 4'd0) begin
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // On a single-cycle transaction the index is still on the bus, not yet captured.
   assign rd_idx     = (state_q == IDLE) ? req_idx : idx_q;
   assign load_rdata = (state_d == RESP) && (state_q != RESP) && !is_write_d;
   assign commit     = (state_q == RESP) && is_write_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= 4'd0;
         idx_q      <= '0;
         wdata_q    <= 32'd0;
         be_q       <= 4'd0;
         is_write_q <= 1'b0;
         resp_q     <= 1'b0;
         rdata_q    <= 32'd0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         wdata_q    <= wdata_d;
         be_q       <= be_d;
         is_write_q <= is_write_d;
         resp_q     <= (state_d == RESP);
         if (load_rdata) begin
            rdata_q <= mem_array[rd_idx];
         end
      end
   end

   // Array contents are deliberately left out of reset.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (commit && be_q[i]) begin
            mem_array[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
         end
      end
   end

   assign mem_resp  = resp_q;
   assign mem_rdata = rdata_q;

`ifdef MEM_RESP_PROTOCOL_CHECK_EN
   logic perr_q;
   logic held;
   logic viol;

   always_comb begin
      held = is_write_q ? mem_write : mem_read;
      viol = mem_read & mem_write;
      if (state_q == BUSY) begin
         if (!held) begin
            viol = 1'b1;
         end else if ((req_idx != idx_q) || (mem_wdata != wdata_q) ||
                      (mem_byte_enable != be_q)) begin
            viol = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perr_q <= 1'b0;
      end else if (viol) begin
         perr_q <= 1'b1;
      end
   end

   assign proto_err = perr_q;
`else
   assign proto_err = 1'b0;
`endif

endmodule
